// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: owns the PC and issues one cache request at a
// time. Returned instructions go into a DEPTH-entry queue that feeds decode
// over valid/ready. Branch redirects flush the queue and squash any response
// still in flight. An all-zero instruction stops fetch.
module fetch_queue_unit #(
    parameter int ADDR_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_WIDTH-1:0]  entry,
    output logic                   req_valid,
    output logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic                   req_ready,
    input  logic                   resp_valid,
    input  logic [INSTR_WIDTH-1:0] resp_instr,
    input  logic                   redirect,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   out_valid,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0]  out_pc,
    output logic [ADDR_WIDTH-1:0]  out_npc,
    input  logic                   out_ready,
    output logic                   halted,
    output logic [CNT_WIDTH-1:0]   fetch_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HALTED} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]  req_pc_q, req_pc_d;
    logic                   squash_q, squash_d;
    logic                   halted_q, halted_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]       count_q, count_d;
    logic [CNT_WIDTH-1:0]   fetch_count_q, fetch_count_d;

    logic [INSTR_WIDTH-1:0] instr_mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0]  pc_mem_q    [DEPTH];
    logic [ADDR_WIDTH-1:0]  npc_mem_q   [DEPTH];
    logic [DEPTH-1:0]       wr_en;

    logic enq;
    logic deq;
    logic req_fire;

    assign req_valid   = (state_q == S_REQ) && (count_q < OCC_W'(DEPTH));
    assign req_addr    = pc_q;
    assign req_fire    = req_valid && req_ready;
    assign out_valid   = (count_q != '0);
    assign deq         = out_valid && out_ready;
    assign out_instr   = instr_mem_q[rd_ptr_q];
    assign out_pc      = pc_mem_q[rd_ptr_q];
    assign out_npc     = npc_mem_q[rd_ptr_q];
    assign halted      = halted_q;
    assign fetch_count = fetch_count_q;

    // One write enable per queue slot, selected by the write pointer
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
        assign wr_en[gi] = enq && (wr_ptr_q == PTR_W'(gi));
    end

    // Next-state logic: fetch FSM, queue pointers, redirect override
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        squash_d      = squash_q;
        halted_d      = halted_q;
        enq           = 1'b0;
        fetch_count_d = fetch_count_q + CNT_WIDTH'(deq);

        case (state_q)
            S_REQ: begin
                if (req_fire) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + ADDR_WIDTH'(4);
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (resp_valid) begin
                    state_d = S_REQ;
                    if (squash_q) begin
                        squash_d = 1'b0;
                    end else if (resp_instr == '0) begin
                        halted_d = 1'b1;
                        state_d  = S_HALTED;
                    end else begin
                        enq = 1'b1;
                    end
                end
            end
            default: begin
                // Halted: queue keeps draining, fetch waits for a redirect
            end
        endcase

        // A response arriving in the same cycle as a redirect is stale too
        if (redirect) begin
            enq      = 1'b0;
            pc_d     = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
            halted_d = 1'b0;
            case (state_q)
                S_REQ: begin
                    if (req_fire) squash_d = 1'b1;
                end
                S_WAIT: begin
                    if (resp_valid) begin
                        state_d  = S_REQ;
                        squash_d = 1'b0;
                    end else begin
                        squash_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase
        end

        rd_ptr_d = rd_ptr_q + PTR_W'(deq);
        wr_ptr_d = wr_ptr_q + PTR_W'(enq);
        count_d  = count_q + OCC_W'(enq) - OCC_W'(deq);
        if (redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_REQ;
            pc_q          <= entry;
            req_pc_q      <= '0;
            squash_q      <= 1'b0;
            halted_q      <= 1'b0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            squash_q      <= squash_d;
            halted_q      <= halted_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Queue storage; cleared on reset so head outputs read zero afterwards
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
                npc_mem_q[i]   <= '0;
            end else if (wr_en[i]) begin
                instr_mem_q[i] <= resp_instr;
                pc_mem_q[i]    <= req_pc_q;
                npc_mem_q[i]   <= req_pc_q + ADDR_WIDTH'(4);
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Randomised bench for fetch_queue_unit. The bench acts as the cache and the
// decode stage. A transaction-level model predicts which instructions must
// reach decode, and a negedge monitor compares each delivery against it.
module tb_fetch_queue_unit;
    localparam int AW = 64;
    localparam int IW = 32;
    localparam int D  = 4;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] entry;
    logic          req_valid;
    logic [AW-1:0] req_addr;
    logic          req_ready;
    logic          resp_valid;
    logic [IW-1:0] resp_instr;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          out_valid;
    logic [IW-1:0] out_instr;
    logic [AW-1:0] out_pc;
    logic [AW-1:0] out_npc;
    logic          out_ready;
    logic          halted;
    logic [CW-1:0] fetch_count;

    always #5 clk = ~clk;

    fetch_queue_unit #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .DEPTH(D), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .entry(entry),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_instr(resp_instr),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .out_npc(out_npc), .out_ready(out_ready),
        .halted(halted), .fetch_count(fetch_count)
    );

    typedef struct {
        logic [IW-1:0] instr;
        logic [AW-1:0] pc;
    } exp_t;

    int checks   = 0;
    int failures = 0;

    // Reference model state (transaction level)
    exp_t          exp_q[$];
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_req_pc;
    bit            m_out;
    bit            m_stale;
    bit            m_halted;
    int            m_lat;
    int unsigned   m_delivered;
    bit            in_reset = 1'b1;

    // Events decided for the coming clock edge
    bit            a_acc;
    bit            a_resp;
    bit            a_redir;
    logic [AW-1:0] a_tgt;
    logic [IW-1:0] a_instr;

    // Stimulus knobs (percent probabilities)
    int p_ready;
    int p_redir;
    int p_zero;
    int p_out;
    int max_lat;

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every delivery to decode pops the oldest expected instruction
    always @(negedge clk) begin : monitor
        exp_t e;
        if (in_reset) begin
            m_delivered = 0;
        end else begin
            check("out_valid", AW'(out_valid), AW'(exp_q.size() != 0));
            check("fetch_count", AW'(fetch_count), AW'(m_delivered));
            if (out_valid && out_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("out_instr", AW'(out_instr), AW'(e.instr));
                check("out_pc", out_pc, e.pc);
                check("out_npc", out_npc, e.pc + 64'd4);
                m_delivered++;
                $display("deliver pc=%h instr=%h count=%0d", out_pc, out_instr, m_delivered);
            end
        end
    end

    // Apply the events of the edge that just happened to the model
    task automatic commit();
        exp_t t;
        if (a_redir) begin
            exp_q.delete();
            m_halted = 1'b0;
        end
        if (a_resp) begin
            m_out = 1'b0;
            if (!m_stale && !a_redir) begin
                if (a_instr == '0) begin
                    m_halted = 1'b1;
                end else begin
                    t.instr = a_instr;
                    t.pc    = m_req_pc;
                    exp_q.push_back(t);
                end
            end
            m_stale = 1'b0;
        end else if (a_redir && m_out) begin
            m_stale = 1'b1;
        end
        if (a_acc) begin
            m_req_pc = m_pc;
            m_out    = 1'b1;
            m_stale  = a_redir;
            m_lat    = $urandom_range(0, max_lat - 1);
        end
        if (a_redir) m_pc = {a_tgt[AW-1:2], 2'b00};
        else if (a_acc) m_pc = m_pc + 64'd4;
        a_acc = 0; a_resp = 0; a_redir = 0;
    endtask

    // Check request-side outputs and choose inputs for the next edge
    task automatic step();
        bit            exp_rv;
        logic [IW-1:0] r;
        exp_rv = !m_out && !m_halted && (exp_q.size() < D);
        check("req_valid", AW'(req_valid), AW'(exp_rv));
        check("halted", AW'(halted), AW'(m_halted));
        if (exp_rv) check("req_addr", req_addr, m_pc);

        req_ready   = ($urandom_range(0, 99) < p_ready);
        out_ready   = ($urandom_range(0, 99) < p_out);
        redirect    = ($urandom_range(0, 99) < p_redir);
        redirect_pc = {$urandom, $urandom};
        if (m_out && m_lat == 0) begin
            resp_valid = 1'b1;
            r = $urandom;
            if (r == '0) r = 32'h13;
            resp_instr = ($urandom_range(0, 99) < p_zero) ? '0 : r;
        end else begin
            resp_valid = 1'b0;
            resp_instr = $urandom;
            if (m_out) m_lat--;
        end
        a_acc   = exp_rv && req_ready;
        a_resp  = resp_valid;
        a_redir = redirect;
        a_tgt   = redirect_pc;
        a_instr = resp_instr;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            commit();
            #1;
            step();
        end
    endtask

    task automatic do_reset(input logic [AW-1:0] ent);
        in_reset    = 1'b1;
        reset       = 1'b1;
        entry       = ent;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_instr  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b0;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        m_pc     = ent;
        m_out    = 1'b0;
        m_stale  = 1'b0;
        m_halted = 1'b0;
        m_lat    = 0;
        exp_q.delete();
        a_acc = 0; a_resp = 0; a_redir = 0;
        check("rst_req_valid", AW'(req_valid), 64'd1);
        check("rst_req_addr", req_addr, ent);
        check("rst_out_valid", AW'(out_valid), 64'd0);
        check("rst_out_instr", AW'(out_instr), 64'd0);
        check("rst_out_pc", out_pc, 64'd0);
        check("rst_out_npc", out_npc, 64'd0);
        check("rst_halted", AW'(halted), 64'd0);
        check("rst_fetch_count", AW'(fetch_count), 64'd0);
        $display("reset entry=%h", ent);
        in_reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        max_lat = 1;
        repeat (2) @(posedge clk);
        do_reset(64'h1000);

        // Straight-line fetch, single-cycle cache, decode always ready
        p_ready = 100; p_redir = 0; p_zero = 0; p_out = 100; max_lat = 1;
        run(30);

        // Back-pressure from decode fills the queue, then drains it
        p_out = 5;
        run(40);
        p_out = 100;
        run(10);

        // Mixed traffic: redirects, halts, variable cache latency
        p_ready = 70; p_redir = 6; p_zero = 4; p_out = 60; max_lat = 3;
        run(3000);

        // Reset mid-operation with an entry point close to address wrap
        do_reset(64'hFFFF_FFFF_FFFF_FFF4);
        p_redir = 0; p_zero = 0; p_out = 80; max_lat = 2;
        run(40);

        p_redir = 6; p_zero = 4; p_out = 60;
        run(1000);

        do_reset(64'h1000);
        run(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Parametrised instruction-fetch front end sitting between the instruction cache and decode. It owns the PC, issues one fetch request at a time to the cache, and buffers returned instructions in a DEPTH-entry queue. Instructions are delivered to decode over a valid/ready handshake. It adds branch redirect with queue flush and stale-response squash, halt-on-zero-instruction detection, and a delivered-instruction counter.

Parameters:
ADDR_WIDTH, 64, PC / fetch address width
INSTR_WIDTH, 32, instruction word width
DEPTH, 4, fetch queue entries (power of 2, >= 2)
CNT_WIDTH, 32, width of the delivered-instruction counter

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
entry  in  ADDR_WIDTH  program entry point, loaded into PC on reset
req_valid  out  1  fetch request to cache
req_addr  out  ADDR_WIDTH  fetch address (= PC)
req_ready  in  1  cache accepts request
resp_valid  in  1  cache returns instruction for the outstanding request
resp_instr  in  INSTR_WIDTH  returned instruction word
redirect  in  1  branch taken from memory stage
redirect_pc  in  ADDR_WIDTH  branch target
out_valid  out  1  queue head valid to decode
out_instr  out  INSTR_WIDTH  head instruction
out_pc  out  ADDR_WIDTH  head instruction PC
out_npc  out  ADDR_WIDTH  head PC + 4
out_ready  in  1  decode accepts head
halted  out  1  all-zero instruction fetched; fetch stopped
fetch_count  out  CNT_WIDTH  instructions delivered to decode

Behaviour:
- Reset (synchronous; also wins mid-operation): PC <= entry, state REQ, queue empty, squash flag 0, halted 0, fetch_count 0. All outputs are 0 in the cycle after reset, except req_valid, which is 1 and req_addr = entry.
- FSM states: REQ, WAIT, HALTED.
- REQ: req_valid = (count < DEPTH), req_addr = PC. On req_valid & req_ready: latch req_pc <= PC, PC <= PC+4 (mod 2^ADDR_WIDTH), go WAIT.
- WAIT: req_valid = 0. On resp_valid:
  - if squash flag is set: discard, clear flag, go REQ;
  - else if resp_instr == 0: do not enqueue, set halted, go HALTED;
  - else enqueue {resp_instr, req_pc, req_pc+4}, go REQ.
- HALTED: req_valid = 0. The queue still drains to decode. Only reset or redirect leaves this state.
- Only one request is outstanding at a time. Minimum latency: request accepted in cycle t, response in t+1, out_valid in t+2.
- Queue: out_valid = (count != 0); head fields come straight from registers. Dequeue on out_valid & out_ready. Read and write pointers wrap modulo DEPTH. Enqueue cannot overflow, because a request is only issued when count < DEPTH.
- Redirect (any state, highest priority after reset):
  - queue flushed, count <= 0;
  - PC <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00}; redirect beats PC+4 in the same cycle;
  - halted cleared.
- Redirect state transitions:
  - in REQ with no handshake: stay in REQ;
  - in REQ with a handshake in the same cycle: go WAIT with squash = 1;
  - in WAIT without resp_valid: squash = 1;
  - in WAIT with resp_valid in the same cycle: the response is discarded and the FSM goes to REQ;
  - in HALTED: go REQ.
- Redirect together with out_valid & out_ready in the same cycle: the handshake completes and fetch_count increments; the queue is then empty.
- fetch_count increments on each out_valid & out_ready and wraps modulo 2^CNT_WIDTH.
- req_valid, once asserted in REQ, is held with a stable req_addr until req_ready or redirect.

Test Plan:
- entry=0x1000, cache returns 0x00000013 each request with 1-cycle latency, out_ready=1 -> out_pc sequence 0x1000, 0x1004, 0x1008; out_npc = out_pc+4; fetch_count=3 after three deliveries.
- out_ready=0, DEPTH=4 -> exactly 4 entries queued, req_valid stays 0; raise out_ready -> 4 deliveries in consecutive cycles, then fetching resumes at 0x1010.
- Redirect to 0x2002 while in WAIT, response 0x00100093 arrives next cycle -> response discarded, queue empty, next req_addr = 0x2000.
- Redirect in the same cycle as resp_valid, and separately in the same cycle as out handshake with 2 entries queued -> no stale enqueue; count=0; fetch_count +1.
- resp_instr=0 at PC 0x100C -> halted=1, req_valid=0, prior entries still drain; then redirect to 0x3000 -> halted=0, req_addr=0x3000.
- PC=0xFFFF_FFFF_FFFF_FFFC fetch -> next req_addr=0x0; assert reset while in WAIT -> next cycle req_addr=entry, out_valid=0, fetch_count=0.
